// File: rtl/beta_mem_arbiter_pkg.sv
// Shared Beta memory arbiter definitions: state encodings,
// requester IDs and parameter defaults.
package beta_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  localparam int unsigned TIMEOUT_DEF  = 16;

  // Bits needed to count up to t without wrapping
  function automatic int unsigned cnt_width(int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/beta_mem_arbiter_timer.sv
// ACCESS-phase watchdog: counts cycles since start, flags
// the final permitted cycle.
module access_timer
  import beta_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam bit          EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] LAST =
    EN ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = '0;
    else if (enable && cnt_q != LAST)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = EN && enable && (cnt_q == LAST);

endmodule

// File: rtl/beta_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port,
// fixed data priority, with optional access timeout.
module beta_mem_arbiter
  import beta_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  state_t      state_q;
  req_id_t     id_q;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        grant, in_acc, expired;

  assign grant  = (state_q == IDLE) && (d_req || if_req);
  assign in_acc = (state_q == ACCESS);

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (grant),
    .enable  (in_acc),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= REQ_IF;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (d_req) begin
            state_q <= ACCESS;
            id_q    <= REQ_D;
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
          end else if (if_req) begin
            state_q <= ACCESS;
            id_q    <= REQ_IF;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
          end
        end
        ACCESS: begin
          // A ready on the last permitted cycle still completes normally
          if (mem_ready || expired) begin
            state_q <= RESP;
            err_q   <= !mem_ready;
            if (!we_q) begin
              if (id_q == REQ_D)
                d_rdata_q  <= mem_ready ? mem_rdata : ERR_DATA;
              else
                if_rdata_q <= mem_ready ? mem_rdata : ERR_DATA;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = in_acc && !we_q;
  assign mem_we    = in_acc && we_q;
  assign if_ack    = (state_q == RESP) && (id_q == REQ_IF);
  assign d_ack     = (state_q == RESP) && (id_q == REQ_D);
  assign bus_err   = (state_q == RESP) && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter: vector table,
// contention/reset sequences and randomized transactions.
module tb_beta_mem_arbiter;

  localparam int unsigned TO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ready, bus_err;

  always #5 clk = ~clk;

  beta_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          waits;
    int          lat;
    int          strobes;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  int errs = 0;
  int checks = 0;
  logic [31:0] m_if, m_d;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit d, bit we, logic [31:0] a,
      logic [31:0] wd, logic [31:0] md, int w, int lat, int st,
      bit e, logic [31:0] rd);
    vec_t v;
    v.is_d = d; v.we = we; v.addr = a; v.wdata = wd;
    v.mdata = md; v.waits = w; v.lat = lat; v.strobes = st;
    v.err = e; v.rdata = rd;
    return v;
  endfunction

  // Transaction-level reference: wait states vs. timeout budget
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    if (v.waits < int'(TO)) begin
      r.lat = v.waits + 2; r.strobes = v.waits + 1; r.err = 0;
    end else begin
      r.lat = TO + 1; r.strobes = TO; r.err = 1;
    end
    if (v.we)      r.rdata = m_d;
    else if (r.err) r.rdata = ERRD;
    else           r.rdata = v.mdata;
    return r;
  endfunction

  // Called just after a rising edge; returns just after one.
  task automatic run_txn(input vec_t v, output int lat,
      output int strobes, output bit err,
      output logic [31:0] rd, output bit bad);
    int acc;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    mem_ready = 0; acc = 0; lat = -1; strobes = 0;
    err = 0; bad = 0; rd = '0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        strobes++; acc++;
        if (mem_addr !== v.addr || mem_we !== v.we ||
            mem_re !== !v.we || (v.we && mem_wdata !== v.wdata))
          bad = 1;
      end
      mem_ready = (acc > v.waits);
      mem_rdata = mem_ready ? v.mdata : $urandom;
      if (d_ack || if_ack) begin
        lat = i; err = bus_err;
        rd = v.is_d ? d_rdata : if_rdata;
        if (v.is_d ? if_ack : d_ack) bad = 1;
      end
    end
    @(posedge clk); #1;
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    @(negedge clk);
    if (if_ack || d_ack || bus_err) bad = 1;
    @(posedge clk); #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat, st; bit err, bad; logic [31:0] rd;
    run_txn(v, lat, st, err, rd, bad);
    chk({tag, ".lat"}, lat, v.lat);
    chk({tag, ".strobes"}, st, v.strobes);
    chk({tag, ".bus_err"}, err, v.err);
    chk({tag, ".rdata"}, rd, v.rdata);
    chk({tag, ".proto"}, bad, 0);
    if (v.is_d) m_d = v.rdata; else m_if = v.rdata;
    chk({tag, ".if_rdata_hold"}, if_rdata, m_if);
    chk({tag, ".d_rdata_hold"}, d_rdata, m_d);
  endtask

  function automatic logic any_out();
    return |{if_ack, d_ack, bus_err, mem_re, mem_we,
             mem_addr, mem_wdata, if_rdata, d_rdata};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn, inn, di, ii, acks;
    logic [31:0] dr, ir;
    vec_t v;

    rst = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    m_if = 0; m_d = 0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", any_out(), 0);
    rst = 0;
    @(posedge clk); #1;

    tbl[0] = mk(0, 0, 32'h100, 0, 32'h12345678, 0, 2, 1, 0, 32'h12345678);
    tbl[1] = mk(1, 0, 32'h40, 0, 32'hA5A5A5A5, 1, 3, 2, 0, 32'hA5A5A5A5);
    tbl[2] = mk(1, 1, 32'h8, 32'hCAFEF00D, 32'h11111111, 3, 5, 4, 0, 32'hA5A5A5A5);
    tbl[3] = mk(0, 0, 32'h200, 0, 32'h22222222, 4, 5, 4, 1, ERRD);
    tbl[4] = mk(1, 0, 32'h44, 0, 32'h33333333, 7, 5, 4, 1, ERRD);
    tbl[5] = mk(0, 0, 32'h104, 0, 32'h0BADF00D, 2, 4, 3, 0, 32'h0BADF00D);
    tbl[6] = mk(1, 1, 32'hC, 32'h13572468, 32'h44444444, 0, 2, 1, 0, ERRD);
    for (int k = 0; k < 7; k++)
      apply(tbl[k], $sformatf("vec%0d", k));

    // Simultaneous requests: data first, fetch right after
    if_req = 1; if_addr = 32'h180;
    d_req = 1; d_we = 0; d_addr = 32'h40; mem_ready = 1;
    dn = 0; inn = 0; di = -1; ii = -1; dr = 0; ir = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mem_rdata = mem_addr ^ 32'h5A5A0000;
      if (d_ack) begin dn++; di = i; dr = d_rdata; d_req = 0; end
      if (if_ack) begin inn++; ii = i; ir = if_rdata; if_req = 0; end
    end
    mem_ready = 0;
    chk("cont.d_ack_count", dn, 1);
    chk("cont.if_ack_count", inn, 1);
    chk("cont.d_ack_cycle", di, 2);
    chk("cont.if_ack_cycle", ii, 5);
    chk("cont.d_rdata", dr, 32'h5A5A0040);
    chk("cont.if_rdata", ir, 32'h5A5A0180);
    m_d = 32'h5A5A0040; m_if = 32'h5A5A0180;
    @(posedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      v.is_d = $urandom_range(0, 1);
      v.we = v.is_d ? $urandom_range(0, 1) : 0;
      v.addr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.mdata = $urandom;
      v.waits = $urandom_range(0, 6);
      apply(model(v), $sformatf("rnd%0d", k));
    end

    // Reset during a wait state, fetch still held afterwards
    if_req = 1; if_addr = 32'h300; mem_ready = 0; acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(if_ack | d_ack);
    end
    chk("rstmid.pre_mem_re", mem_re, 1);
    #1 rst = 1;
    #1 chk("rstmid.async_outputs", any_out(), 0);
    @(negedge clk);
    acks += int'(if_ack | d_ack);
    chk("rstmid.held_outputs", any_out(), 0);
    rst = 0; mem_ready = 1; mem_rdata = 32'h77665544;
    ii = -1; ir = 0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (d_ack) acks++;
      if (if_ack && ii < 0) begin ii = i; ir = if_rdata; if_req = 0; end
    end
    mem_ready = 0;
    chk("rstmid.no_stray_ack", acks, 0);
    chk("rstmid.regrant_cycle", ii, 2);
    chk("rstmid.regrant_rdata", ir, 32'h77665544);
    chk("rstmid.d_rdata_cleared", d_rdata, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/beta_mem_arbiter.md
BETA_MEM_ARBITER -- requirements
Module: beta_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum ACCESS cycles before the access is aborted; 0 disables the timeout.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on an aborted access.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch request; held until if_ack.
REQ-006 if_addr  in  32  fetch address; stable while if_req is high.
REQ-007 if_rdata  out  32  fetch data; valid while if_ack is high.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request; held until d_ack.
REQ-010 d_we  in  1  1 = write, 0 = read; stable while d_req is high.
REQ-011 d_addr, d_wdata  in  32 each  data address and write data; stable while d_req is high.
REQ-012 d_rdata  out  32  read data; valid while d_ack is high.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 mem_addr, mem_wdata  out  32 each  shared memory address and write data.
REQ-015 mem_re, mem_we  out  1 each  memory read and write strobes; never both high.
REQ-016 mem_rdata  in  32  memory read data; sampled when mem_ready is high.
REQ-017 mem_ready  in  1  memory completes the current access this cycle.
REQ-018 bus_err  out  1  one-cycle pulse, coincident with the ack of an aborted access.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-020 IDLE SHALL take d_req over if_req when both are high (fixed data priority); the losing request stays pending.
REQ-021 On a grant, the block SHALL register the granted addr, wdata, we and requester ID, and SHALL move to ACCESS.
REQ-022 In ACCESS, mem_re or mem_we SHALL be high, and mem_addr/mem_wdata SHALL be driven from the registered copies.
REQ-023 In ACCESS with mem_ready high, the block SHALL latch mem_rdata (reads only) and move to RESP.
REQ-024 In RESP, the block SHALL pulse the granted requester's ack for exactly one cycle, with its rdata valid, and SHALL then return to IDLE.
REQ-025 Minimum latency SHALL be 3 cycles: request sampled in cycle N, ACCESS in N+1 (mem_ready high), ack in N+2, next grant possible in N+3.
REQ-026 Each wait-state cycle (mem_ready low in ACCESS) SHALL add exactly one cycle of latency.
REQ-027 A requester SHALL drop req in the cycle after its ack unless it is issuing a new request; a req still high in IDLE is a new request.
REQ-028 if_rdata and d_rdata SHALL hold their last value outside ack; a write ack SHALL leave d_rdata unchanged.
REQ-029 An ACCESS cycle counter SHALL reset on entry to ACCESS; when it reaches TIMEOUT (TIMEOUT != 0) without mem_ready, the block SHALL deassert the strobes, return ERR_DATA as read data, and enter RESP with bus_err high during the ack.
REQ-030 mem_ready sampled high in IDLE or RESP SHALL be ignored.
REQ-031 The TIMEOUT counter SHALL be wide enough to hold TIMEOUT without wrapping.

Reset
REQ-032 rst high SHALL immediately force IDLE, clear the grant, counter and latched data, and drive every output to 0 (if_rdata and d_rdata = 32'h0).
REQ-033 A reset mid-ACCESS SHALL drop the access with no ack; a req still held after rst falls SHALL be granted afresh.

Structure
REQ-034 A shared Beta package SHALL hold the state encodings (IDLE=0, ACCESS=1, RESP=2), the requester-ID constants and the ERR_DATA default.
REQ-035 The timeout counter SHALL be one sub-module, access_timer (inputs: start, enable; output: expired).

Verification
REQ-036 Single fetch: if_req, addr 0x100, mem_ready high on the first ACCESS cycle, rdata 0x12345678 -> if_ack 2 cycles after sample, if_rdata 0x12345678.
REQ-037 Contention: if_req and d_req (read 0x40) raised in the same cycle -> data served first; fetch granted in the cycle after d_ack; each ack exactly once.
REQ-038 Write with 3 wait states: d_we=1, addr 0x8, wdata 0xCAFEF00D -> mem_we high for 4 cycles with those values; d_ack 5 cycles after sample; d_rdata unchanged.
REQ-039 Timeout: TIMEOUT=4, mem_ready held low -> strobes high for 4 cycles, then ack with rdata 0xDEADBEEF and bus_err pulse.
REQ-040 Reset mid-ACCESS: rst pulsed during a wait state -> all outputs 0 asynchronously, no ack; the held if_req is regranted after release.
